// File: rtl/btn_evt_ctrl.sv
// btn_evt_ctrl: turns debounced active-low buttons into one serialized press/release/long/repeat event stream
// Ports: clk, rst_n (async, active-low); btn_n[N_BTN] debounced levels, 0 = pressed;
//        evt_valid/evt_ready/evt_id/evt_type FWFT event output (type 00 press, 01 release, 10 long, 11 repeat);
//        ovf sticky drop flag, cleared by clr_ovf (a drop in the same cycle wins).
// Build option: define BTN_AUTO_REPEAT_EN to emit repeat events every REPEAT_TICKS ticks while held.
module btn_evt_ctrl #(
  parameter int N_BTN        = 4,
  parameter int ID_W         = 2,
  parameter int TICK_DIV     = 50000,
  parameter int LONG_TICKS   = 50,
  parameter int REPEAT_TICKS = 10,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic [1:0]       evt_type,
  output logic             ovf,
  input  logic             clr_ovf
);
  localparam int PW   = $clog2(TICK_DIV);
  localparam int HMAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int HW   = $clog2(HMAX + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int EW   = ID_W + 2;

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} st_e;

  logic [PW-1:0]    presc_q, presc_d;
  logic             tick;
  st_e              st_q [N_BTN];
  st_e              st_d [N_BTN];
  logic [HW-1:0]    hold_q [N_BTN];
  logic [HW-1:0]    hold_d [N_BTN];
  logic [N_BTN-1:0] post;
  logic [1:0]       post_type [N_BTN];
  logic [N_BTN-1:0] sv_q, sv_d, drop;
  logic [1:0]       stype_q [N_BTN];
  logic [1:0]       stype_d [N_BTN];
  logic [ID_W-1:0]  rr_q, rr_d, gnt_idx;
  logic             gnt_vld, g;
  logic [1:0]       gnt_type;
  int               best;
  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [EW-1:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full, push, pop, ovf_q, ovf_d;

  assign tick    = presc_q == PW'(TICK_DIV - 1);
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      st_d[i]      = st_q[i];
      hold_d[i]    = hold_q[i];
      post[i]      = 1'b0;
      post_type[i] = 2'b00;
      if (st_q[i] == IDLE) begin
        if (!btn_n[i]) begin
          post[i]   = 1'b1;
          st_d[i]   = PRESSED;
          hold_d[i] = '0;
        end
      end else if (btn_n[i]) begin
        // release outranks a coincident tick
        post[i]      = 1'b1;
        post_type[i] = 2'b01;
        st_d[i]      = IDLE;
      end else if (tick && st_q[i] == PRESSED) begin
        if (hold_q[i] == HW'(LONG_TICKS - 1)) begin
          post[i]      = 1'b1;
          post_type[i] = 2'b10;
          st_d[i]      = HELD;
          hold_d[i]    = '0;
        end else begin
          hold_d[i] = hold_q[i] + 1'b1;
        end
      end
`ifdef BTN_AUTO_REPEAT_EN
      else if (tick) begin
        if (hold_q[i] == HW'(REPEAT_TICKS - 1)) begin
          post[i]      = 1'b1;
          post_type[i] = 2'b11;
          hold_d[i]    = '0;
        end else begin
          hold_d[i] = hold_q[i] + 1'b1;
        end
      end
`endif
    end
  end

  // round-robin: pick the valid slot at the smallest rotated distance from rr_q
  assign full = cnt_q == (AW + 1)'(FIFO_DEPTH);
  always_comb begin
    best    = N_BTN;
    gnt_idx = '0;
    for (int j = 0; j < N_BTN; j++)
      if (sv_q[j] && ((j - int'(rr_q) + N_BTN) % N_BTN) < best) begin
        best    = (j - int'(rr_q) + N_BTN) % N_BTN;
        gnt_idx = ID_W'(j);
      end
    gnt_vld = !full && best < N_BTN;
    rr_d    = gnt_vld ? ID_W'((int'(gnt_idx) + 1) % N_BTN) : rr_q;
  end

  // a granted slot frees up this cycle, so a new post refills it without a drop
  always_comb begin
    gnt_type = 2'b00;
    g        = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      g          = gnt_vld && gnt_idx == ID_W'(i);
      gnt_type   = g ? stype_q[i] : gnt_type;
      drop[i]    = post[i] && sv_q[i] && !g;
      sv_d[i]    = post[i] || (sv_q[i] && !g);
      stype_d[i] = (post[i] && (!sv_q[i] || g)) ? post_type[i] : stype_q[i];
    end
  end

  assign evt_valid = cnt_q != '0;
  assign push      = gnt_vld;
  assign pop       = evt_valid && evt_ready;
  assign evt_id    = evt_valid ? mem_q[rd_q][EW-1:2] : '0;
  assign evt_type  = evt_valid ? mem_q[rd_q][1:0] : 2'b00;
  assign ovf       = ovf_q;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = {gnt_idx, gnt_type};
    wr_d  = push ? wr_q + 1'b1 : wr_q;
    rd_d  = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
    ovf_d = |drop || (ovf_q && !clr_ovf);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      presc_q <= '0;
      st_q    <= '{default: IDLE};
      hold_q  <= '{default: '0};
      sv_q    <= '0;
      stype_q <= '{default: '0};
      rr_q    <= '0;
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      st_q    <= st_d;
      hold_q  <= hold_d;
      sv_q    <= sv_d;
      stype_q <= stype_d;
      rr_q    <= rr_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
endmodule

// File: tb/tb_btn_evt_ctrl.sv
// tb_btn_evt_ctrl: directed and random stimulus checked every cycle against an event-level model
module tb_btn_evt_ctrl;
  localparam int N = 4, TD = 4, LT = 3, RT = 2, DEPTH = 4;
`ifdef BTN_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, evt_ready = 1'b1, clr_ovf = 1'b0;
  logic [N-1:0] btn_n = '1;
  logic evt_valid, ovf;
  logic [1:0] evt_id, evt_type;

  always #5 clk = ~clk;

  btn_evt_ctrl #(.N_BTN(N), .ID_W(2), .TICK_DIV(TD), .LONG_TICKS(LT),
                 .REPEAT_TICKS(RT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_id(evt_id), .evt_type(evt_type), .ovf(ovf), .clr_ovf(clr_ovf));

  int vectors = 0, miscompares = 0;
  int m_presc, m_rr;
  bit m_pr [N];
  int m_ticks [N];
  bit m_sv [N];
  logic [1:0] m_st [N];
  logic [3:0] m_q [$];
  logic [3:0] log_q [$];
  bit m_ovf;

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic m_reset();
    m_presc = 0; m_rr = 0; m_ovf = 0;
    m_q.delete();
    for (int i = 0; i < N; i++) begin m_pr[i] = 0; m_ticks[i] = 0; m_sv[i] = 0; m_st[i] = 2'b00; end
  endtask

  // event-level model: "held for k ticks" instead of per-state counters
  task automatic m_step();
    bit tk, set;
    int g;
    bit ev [N];
    logic [1:0] et [N];
    tk = m_presc == TD - 1;
    m_presc = (m_presc + 1) % TD;
    g = -1;
    if (m_q.size() < DEPTH)
      for (int k = 0; k < N; k++) if (g < 0 && m_sv[(m_rr + k) % N]) g = (m_rr + k) % N;
    for (int i = 0; i < N; i++) begin
      ev[i] = 0; et[i] = 2'b00;
      if (!m_pr[i] && !btn_n[i]) begin ev[i] = 1; m_pr[i] = 1; m_ticks[i] = 0; end
      else if (m_pr[i] && btn_n[i]) begin ev[i] = 1; et[i] = 2'b01; m_pr[i] = 0; end
      else if (m_pr[i] && tk) begin
        m_ticks[i]++;
        if (m_ticks[i] == LT) begin ev[i] = 1; et[i] = 2'b10; end
        else if (AUTO && m_ticks[i] > LT && (m_ticks[i] - LT) % RT == 0) begin ev[i] = 1; et[i] = 2'b11; end
      end
    end
    if (m_q.size() > 0 && evt_ready) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back({g[1:0], m_st[g]});
      m_sv[g] = 0;
      m_rr = (g + 1) % N;
    end
    set = 0;
    for (int i = 0; i < N; i++)
      if (ev[i]) begin
        if (!m_sv[i]) begin m_sv[i] = 1; m_st[i] = et[i]; end
        else set = 1;
      end
    m_ovf = set || (m_ovf && !clr_ovf);
  endtask

  task automatic step();
    if (rst_n && evt_valid && evt_ready) log_q.push_back({evt_id, evt_type});
    m_step();
    @(posedge clk);
    #1;
    check("evt_valid", evt_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      check("evt_id", evt_id, m_q[0][3:2]);
      check("evt_type", evt_type, m_q[0][1:0]);
    end
    check("ovf", ovf, m_ovf);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int nl, nr;

  initial begin
    do_reset();
    check("rst_valid", evt_valid, 0);
    check("rst_id", evt_id, 0);
    check("rst_type", evt_type, 0);
    check("rst_ovf", ovf, 0);

    // short press on button 2
    log_q.delete();
    btn_n[2] = 1'b0;
    step();
    check("lat_t0_valid", evt_valid, 0);
    step();
    check("lat_t1_valid", evt_valid, 1);
    check("lat_t1_id", evt_id, 2);
    check("lat_t1_type", evt_type, 0);
    repeat (4) step();
    btn_n[2] = 1'b1;
    repeat (6) step();
    check("short_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("short_press", log_q[0], 4'b1000);
      check("short_release", log_q[1], 4'b1001);
    end
    check("short_ovf", ovf, 0);

    // long hold on button 1
    log_q.delete();
    btn_n[1] = 1'b0;
    repeat (40) step();
    btn_n[1] = 1'b1;
    repeat (8) step();
    nl = 0; nr = 0;
    foreach (log_q[k]) begin
      if (log_q[k] == 4'b0110) nl++;
      if (log_q[k] == 4'b0111) nr++;
    end
    check("long_count", nl, 1);
    check("repeat_count_ok", AUTO ? (nr >= 3) : (nr == 0), 1);
    if (log_q.size() >= 3) begin
      check("long_first", log_q[0], 4'b0100);
      check("long_second", log_q[1], 4'b0110);
      check("long_last", log_q[log_q.size() - 1], 4'b0101);
    end else check("long_log_size", log_q.size(), 3);

    // contention right after reset: ids 0..3 in order
    do_reset();
    log_q.delete();
    btn_n = '0;
    repeat (6) step();
    check("cont_count", log_q.size(), 4);
    if (log_q.size() == 4)
      for (int k = 0; k < 4; k++) check("cont_order", log_q[k], {k[1:0], 2'b00});
    btn_n = '1;
    repeat (12) step();

    // backpressure and overflow
    evt_ready = 1'b0;
    btn_n = '0;
    repeat (8) step();
    btn_n = '1;
    repeat (3) step();
    check("bp_ovf_clear", ovf, 0);
    check("bp_valid", evt_valid, 1);
    check("bp_type", evt_type, 0);
    btn_n = '0;
    step();
    check("bp_ovf_set", ovf, 1);
    evt_ready = 1'b1;
    repeat (12) step();
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("clr_ovf", ovf, 0);
    btn_n = '1;
    repeat (10) step();

    // reset while button 0 is in HELD with a non-empty FIFO
    evt_ready = 1'b0;
    btn_n[0] = 1'b0;
    repeat (20) step();
    check("mid_valid_before", evt_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", evt_valid, 0);
    check("mid_rst_ovf", ovf, 0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    step();
    step();
    check("post_rst_valid", evt_valid, 1);
    check("post_rst_id", evt_id, 0);
    check("post_rst_type", evt_type, 0);
    btn_n = '1;
    repeat (8) step();

    // random traffic
    repeat (3000) begin
      if ($urandom_range(0, 15) == 0) btn_n[$urandom_range(0, N - 1)] ^= 1'b1;
      evt_ready = $urandom_range(0, 3) != 0;
      clr_ovf = $urandom_range(0, 31) == 0;
      step();
    end
    btn_n = '1;
    evt_ready = 1'b1;
    clr_ovf = 1'b0;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
